// File: rtl/mmio_event_monitor.sv
// Decodes testbench-signature MMIO accesses and queues numbered, tainted events
// in a first-word-fall-through FIFO. Also sequences end of run: drain, trap policy, SIMLEN cutoff.
module mmio_event_monitor #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 64,
  parameter int                FIFO_DEPTH  = 8,
  parameter int                STOP_DRAIN  = 50,
  parameter logic [ADDR_W-1:0] ADDR_STOP   = 32'h6000_0000,
  parameter logic [ADDR_W-1:0] ADDR_TRAP   = 32'h6000_0008,
  parameter logic [ADDR_W-1:0] ADDR_IREG   = 32'h6000_0010,
  parameter logic [ADDR_W-1:0] ADDR_FREG   = 32'h6000_0018,
  parameter logic [ADDR_W-1:0] ADDR_STREAM = 32'h6000_0020
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mmio_req_i,
  input  logic              mmio_we_i,
  input  logic [ADDR_W-1:0] mmio_addr_i,
  input  logic [DATA_W-1:0] mmio_wdata_i,
  input  logic [DATA_W-1:0] mmio_wdata_t0_i,
  input  logic [31:0]       simlen_i,
  input  logic              dontstop_on_trap_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [2:0]        evt_kind_o,
  output logic [7:0]        evt_idx_o,
  output logic [DATA_W-1:0] evt_data_o,
  output logic [DATA_W-1:0] evt_taint_o,
  output logic              draining_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [31:0]       cycle_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 3 + 8 + 2 * DATA_W;
  localparam logic [PTR_W:0] FULL_CNT       = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0]    STOP_DRAIN_CNT = 32'(STOP_DRAIN);

  localparam logic [2:0] K_STOP   = 3'd0;
  localparam logic [2:0] K_TRAP   = 3'd1;
  localparam logic [2:0] K_IREG   = 3'd2;
  localparam logic [2:0] K_FREG   = 3'd3;
  localparam logic [2:0] K_STREAM = 3'd4;
  localparam logic [2:0] K_SIMLEN = 3'd5;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_drain_cnt;
  logic [31:0]       w_drain_next;
  logic [31:0]       r_cycle;
  logic [7:0]        r_ireg_idx;
  logic [7:0]        r_freg_idx;
  logic [7:0]        r_stream_idx;
  logic              r_simlen_pend;
  logic              r_overflow;

  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic              w_wr;
  logic              w_hit_stop;
  logic              w_hit_trap;
  logic              w_hit_ireg;
  logic              w_hit_freg;
  logic              w_hit_stream;
  logic              w_any_hit;
  logic              w_run;
  logic              w_simlen_hit;
  logic              w_push;
  logic [2:0]        w_push_kind;
  logic [7:0]        w_push_idx;
  logic [DATA_W-1:0] w_push_data;
  logic [DATA_W-1:0] w_push_taint;
  logic              w_valid;
  logic              w_full;
  logic              w_pop;
  logic              w_push_ok;
  logic [ENT_W-1:0]  w_head;

  // Trap is the only signature that also fires on reads.
  assign w_wr         = mmio_req_i & mmio_we_i;
  assign w_hit_stop   = w_wr & (mmio_addr_i == ADDR_STOP);
  assign w_hit_trap   = mmio_req_i & (mmio_addr_i == ADDR_TRAP);
  assign w_hit_ireg   = w_wr & (mmio_addr_i == ADDR_IREG);
  assign w_hit_freg   = w_wr & (mmio_addr_i == ADDR_FREG);
  assign w_hit_stream = w_wr & (mmio_addr_i == ADDR_STREAM);
  assign w_any_hit    = w_hit_stop | w_hit_trap | w_hit_ireg | w_hit_freg | w_hit_stream;
  assign w_run        = (r_state == ST_RUN);
  assign w_simlen_hit = (simlen_i != 32'd0) && (r_cycle == simlen_i - 32'd1) && (r_state != ST_DONE);

  // A pending SIMLEN only exists in DONE, so it never competes with a hit.
  always_comb begin
    w_push       = 1'b0;
    w_push_kind  = '0;
    w_push_idx   = '0;
    w_push_data  = '0;
    w_push_taint = '0;
    if (r_simlen_pend) begin
      w_push      = 1'b1;
      w_push_kind = K_SIMLEN;
    end else if (w_run) begin
      if (w_hit_stop) begin
        w_push      = 1'b1;
        w_push_kind = K_STOP;
      end else if (w_hit_trap) begin
        w_push      = 1'b1;
        w_push_kind = K_TRAP;
      end else if (w_hit_ireg) begin
        w_push       = 1'b1;
        w_push_kind  = K_IREG;
        w_push_idx   = r_ireg_idx;
        w_push_data  = mmio_wdata_i;
        w_push_taint = mmio_wdata_t0_i;
      end else if (w_hit_freg) begin
        w_push       = 1'b1;
        w_push_kind  = K_FREG;
        w_push_idx   = r_freg_idx;
        w_push_data  = mmio_wdata_i;
        w_push_taint = mmio_wdata_t0_i;
      end else if (w_hit_stream) begin
        w_push       = 1'b1;
        w_push_kind  = K_STREAM;
        w_push_idx   = r_stream_idx;
        w_push_data  = mmio_wdata_i;
        w_push_taint = mmio_wdata_t0_i;
      end else if (w_simlen_hit) begin
        w_push      = 1'b1;
        w_push_kind = K_SIMLEN;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_drain_next = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_simlen_hit) begin
          w_state_next = ST_DONE;
        end else if (w_hit_stop || (w_hit_trap && !dontstop_on_trap_i)) begin
          if (STOP_DRAIN == 0) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_DRAIN;
            w_drain_next = STOP_DRAIN_CNT;
          end
        end
      end
      ST_DRAIN: begin
        // Leaving on the last count keeps done exactly STOP_DRAIN+1 cycles after capture.
        w_drain_next = r_drain_cnt - 32'd1;
        if (w_simlen_hit || (r_drain_cnt <= 32'd1)) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_DONE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_RUN;
      r_drain_cnt   <= '0;
      r_cycle       <= '0;
      r_ireg_idx    <= 8'd1;
      r_freg_idx    <= '0;
      r_stream_idx  <= '0;
      r_simlen_pend <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
      if (r_cycle != '1) begin
        r_cycle <= r_cycle + 32'd1;
      end
      if (w_run && w_hit_ireg) begin
        r_ireg_idx <= r_ireg_idx + 8'd1;
      end
      if (w_run && w_hit_freg) begin
        r_freg_idx <= r_freg_idx + 8'd1;
      end
      if (w_run && w_hit_stream) begin
        r_stream_idx <= r_stream_idx + 8'd1;
      end
      r_simlen_pend <= w_run && w_simlen_hit && w_any_hit;
    end
  end

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = w_valid & evt_ready_i;
  assign w_push_ok = w_push & (~w_full | w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {w_push_kind, w_push_idx, w_push_data, w_push_taint};
    end
  end

  // Storage is not reset, so the head fields are masked while the FIFO is empty.
  assign w_head      = r_mem[r_rd_ptr];
  assign evt_valid_o = w_valid;
  assign evt_kind_o  = w_valid ? w_head[ENT_W-1 -: 3] : '0;
  assign evt_idx_o   = w_valid ? w_head[2*DATA_W +: 8] : '0;
  assign evt_data_o  = w_valid ? w_head[DATA_W +: DATA_W] : '0;
  assign evt_taint_o = w_valid ? w_head[0 +: DATA_W] : '0;
  assign draining_o  = (r_state == ST_DRAIN);
  assign done_o      = (r_state == ST_DONE);
  assign overflow_o  = r_overflow;
  assign cycle_o     = r_cycle;

endmodule

// File: tb/tb_mmio_event_monitor.sv
// Self-checking bench for mmio_event_monitor: a vector table plus hand-written end-of-run
// sequences, with an expected-event queue checked whenever the consumer pops.
module tb_mmio_event_monitor;

  localparam int          DRAIN    = 50;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] A_STOP   = 32'h6000_0000;
  localparam logic [31:0] A_TRAP   = 32'h6000_0008;
  localparam logic [31:0] A_IREG   = 32'h6000_0010;
  localparam logic [31:0] A_FREG   = 32'h6000_0018;
  localparam logic [31:0] A_STREAM = 32'h6000_0020;
  localparam logic [2:0]  K_STOP = 3'd0, K_TRAP = 3'd1, K_IREG = 3'd2;
  localparam logic [2:0]  K_FREG = 3'd3, K_STREAM = 3'd4, K_SIMLEN = 3'd5;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        mmio_req_i = 1'b0;
  logic        mmio_we_i = 1'b0;
  logic [31:0] mmio_addr_i = '0;
  logic [63:0] mmio_wdata_i = '0;
  logic [63:0] mmio_wdata_t0_i = '0;
  logic [31:0] simlen_i = '0;
  logic        dontstop_on_trap_i = 1'b1;
  logic        evt_valid_o;
  logic        evt_ready_i = 1'b1;
  logic [2:0]  evt_kind_o;
  logic [7:0]  evt_idx_o;
  logic [63:0] evt_data_o;
  logic [63:0] evt_taint_o;
  logic        draining_o;
  logic        done_o;
  logic        overflow_o;
  logic [31:0] cycle_o;

  always #5 clk = ~clk;

  mmio_event_monitor #(
    .ADDR_W(32), .DATA_W(64), .FIFO_DEPTH(DEPTH), .STOP_DRAIN(DRAIN),
    .ADDR_STOP(A_STOP), .ADDR_TRAP(A_TRAP), .ADDR_IREG(A_IREG),
    .ADDR_FREG(A_FREG), .ADDR_STREAM(A_STREAM)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mmio_req_i(mmio_req_i), .mmio_we_i(mmio_we_i), .mmio_addr_i(mmio_addr_i),
    .mmio_wdata_i(mmio_wdata_i), .mmio_wdata_t0_i(mmio_wdata_t0_i),
    .simlen_i(simlen_i), .dontstop_on_trap_i(dontstop_on_trap_i),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
    .evt_kind_o(evt_kind_o), .evt_idx_o(evt_idx_o),
    .evt_data_o(evt_data_o), .evt_taint_o(evt_taint_o),
    .draining_o(draining_o), .done_o(done_o), .overflow_o(overflow_o),
    .cycle_o(cycle_o)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [7:0]  idx;
    logic [63:0] data;
    logic [63:0] taint;
  } evt_t;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] t0;
    logic        exp;
    logic [2:0]  kind;
    logic [7:0]  idx;
    logic [63:0] edata;
    logic [63:0] etaint;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  evt_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   tb_cyc = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  function automatic void push_exp(input logic [2:0] k, input logic [7:0] i,
                                   input logic [63:0] d, input logic [63:0] t);
    evt_t e;
    e.kind = k; e.idx = i; e.data = d; e.taint = t;
    exp_q.push_back(e);
  endfunction

  task automatic check_pop();
    evt_t e;
    if (evt_valid_o && evt_ready_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got kind=%0d idx=%0d data=0x%0h, required none",
                 evt_kind_o, evt_idx_o, evt_data_o);
      end else begin
        e = exp_q.pop_front();
        if (evt_kind_o !== e.kind || evt_idx_o !== e.idx ||
            evt_data_o !== e.data || evt_taint_o !== e.taint) begin
          n_err++;
          $display("FAIL event: got kind=%0d idx=%0d data=0x%0h taint=0x%0h, required kind=%0d idx=%0d data=0x%0h taint=0x%0h",
                   evt_kind_o, evt_idx_o, evt_data_o, evt_taint_o, e.kind, e.idx, e.data, e.taint);
        end else begin
          $display("pop kind=%0d idx=%0d data=0x%0h taint=0x%0h", evt_kind_o, evt_idx_o, evt_data_o, evt_taint_o);
        end
      end
    end
  endtask

  // One clock: consumer check on the falling edge, then advance past the rising edge.
  task automatic step();
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
    tb_cyc = rst_i ? 0 : tb_cyc + 1;
  endtask

  task automatic idle_bus();
    mmio_req_i = 1'b0; mmio_we_i = 1'b0; mmio_addr_i = '0;
    mmio_wdata_i = '0; mmio_wdata_t0_i = '0;
  endtask

  task automatic mmio(input logic we, input logic [31:0] a, input logic [63:0] d, input logic [63:0] t);
    mmio_req_i = 1'b1; mmio_we_i = we; mmio_addr_i = a;
    mmio_wdata_i = d; mmio_wdata_t0_i = t;
    step();
    idle_bus();
  endtask

  task automatic do_reset();
    exp_q.delete();
    evt_ready_i = 1'b0;
    idle_bus();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    evt_ready_i = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, A_IREG,   64'h11,   64'h0,  1'b1, K_IREG,   8'd1, 64'h11,   64'h0};
    vecs[1]  = '{1'b1, 1'b1, A_IREG,   64'h22,   64'hFF, 1'b1, K_IREG,   8'd2, 64'h22,   64'hFF};
    vecs[2]  = '{1'b1, 1'b1, A_FREG,   64'hAAAA, 64'h5,  1'b1, K_FREG,   8'd0, 64'hAAAA, 64'h5};
    vecs[3]  = '{1'b1, 1'b1, A_STREAM, 64'hCAFE_0000_1234_5678, 64'hF0F0, 1'b1, K_STREAM, 8'd0,
                 64'hCAFE_0000_1234_5678, 64'hF0F0};
    vecs[4]  = '{1'b1, 1'b0, A_IREG,   64'h77,   64'h1,  1'b0, K_STOP,   8'd0, 64'h0,    64'h0};
    vecs[5]  = '{1'b0, 1'b1, A_FREG,   64'h88,   64'h2,  1'b0, K_STOP,   8'd0, 64'h0,    64'h0};
    vecs[6]  = '{1'b1, 1'b1, A_STREAM + 32'd4, 64'h99, 64'h3, 1'b0, K_STOP, 8'd0, 64'h0,  64'h0};
    vecs[7]  = '{1'b1, 1'b0, A_TRAP,   64'h1234, 64'h56, 1'b1, K_TRAP,   8'd0, 64'h0,    64'h0};
    vecs[8]  = '{1'b1, 1'b1, A_TRAP,   64'h4321, 64'h65, 1'b1, K_TRAP,   8'd0, 64'h0,    64'h0};
    vecs[9]  = '{1'b1, 1'b1, A_FREG,   64'hBB,   64'h0,  1'b1, K_FREG,   8'd1, 64'hBB,   64'h0};
    vecs[10] = '{1'b1, 1'b1, A_STREAM, 64'hCC,   64'h1,  1'b1, K_STREAM, 8'd1, 64'hCC,   64'h1};
    vecs[11] = '{1'b1, 1'b1, A_IREG,   64'hDD,   64'h2,  1'b1, K_IREG,   8'd3, 64'hDD,   64'h2};

    // Reset state.
    do_reset();
    check("rst_valid", evt_valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_draining", draining_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_cycle", cycle_o, 0);
    check("rst_kind", evt_kind_o, 0);

    // Table: each vector is one bus cycle; trap with dontstop=1 keeps RUN.
    dontstop_on_trap_i = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].exp) push_exp(vecs[i].kind, vecs[i].idx, vecs[i].edata, vecs[i].etaint);
      mmio_req_i = vecs[i].req; mmio_we_i = vecs[i].we; mmio_addr_i = vecs[i].addr;
      mmio_wdata_i = vecs[i].wdata; mmio_wdata_t0_i = vecs[i].t0;
      step();
      idle_bus();
      check($sformatf("vec%0d_draining", i), draining_o, 0);
    end
    idle(4);
    check("table_queue_empty", exp_q.size(), 0);
    check("table_cycle", cycle_o, tb_cyc);

    // STOP at cycle 20: drain 21..70, done from 71; IREG at 30 ignored.
    do_reset();
    while (tb_cyc < 20) step();
    push_exp(K_STOP, 8'd0, 64'h0, 64'h0);
    mmio(1'b1, A_STOP, 64'h5555, 64'hAAAA);
    while (tb_cyc <= 75) begin
      check($sformatf("stop_draining@%0d", tb_cyc), draining_o, (tb_cyc >= 21 && tb_cyc <= 20 + DRAIN));
      check($sformatf("stop_done@%0d", tb_cyc), done_o, (tb_cyc >= 21 + DRAIN));
      if (tb_cyc == 30) mmio(1'b1, A_IREG, 64'h33, 64'h0);
      else step();
    end
    check("stop_queue_empty", exp_q.size(), 0);

    // TRAP read with dontstop=0 starts drain.
    do_reset();
    dontstop_on_trap_i = 1'b0;
    while (tb_cyc < 5) step();
    push_exp(K_TRAP, 8'd0, 64'h0, 64'h0);
    mmio(1'b0, A_TRAP, 64'hDEAD, 64'hBEEF);
    while (tb_cyc <= 5 + DRAIN + 3) begin
      check($sformatf("trap_draining@%0d", tb_cyc), draining_o, (tb_cyc >= 6 && tb_cyc <= 5 + DRAIN));
      check($sformatf("trap_done@%0d", tb_cyc), done_o, (tb_cyc >= 6 + DRAIN));
      step();
    end
    dontstop_on_trap_i = 1'b1;
    check("trap_queue_empty", exp_q.size(), 0);

    // Overflow: 10 STREAM writes with consumer stalled, idx 8 and 9 dropped.
    do_reset();
    evt_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < DEPTH) push_exp(K_STREAM, 8'(i), 64'(100 + i), 64'(i));
      mmio(1'b1, A_STREAM, 64'(100 + i), 64'(i));
    end
    check("ovf_overflow", overflow_o, 1);
    check("ovf_valid", evt_valid_o, 1);
    evt_ready_i = 1'b1;
    push_exp(K_STREAM, 8'd10, 64'h1010, 64'h10);
    mmio(1'b1, A_STREAM, 64'h1010, 64'h10);
    idle(DEPTH + 3);
    check("ovf_sticky", overflow_o, 1);
    check("ovf_queue_empty", exp_q.size(), 0);

    // Full FIFO with same-cycle pop and FREG push: accepted, no overflow.
    do_reset();
    evt_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_exp(K_FREG, 8'(i), 64'(200 + i), 64'(i + 1));
      mmio(1'b1, A_FREG, 64'(200 + i), 64'(i + 1));
    end
    check("full_overflow", overflow_o, 0);
    evt_ready_i = 1'b1;
    push_exp(K_FREG, 8'd8, 64'h2222, 64'h3);
    mmio(1'b1, A_FREG, 64'h2222, 64'h3);
    check("fullpop_overflow", overflow_o, 0);
    idle(DEPTH + 3);
    check("fullpop_queue_empty", exp_q.size(), 0);

    // Reset mid-drain discards queued events and restarts indices.
    do_reset();
    evt_ready_i = 1'b0;
    mmio(1'b1, A_IREG, 64'h44, 64'h0);
    mmio(1'b1, A_STOP, 64'h0, 64'h0);
    idle(5);
    check("middrain_draining", draining_o, 1);
    check("middrain_valid", evt_valid_o, 1);
    do_reset();
    check("postrst_valid", evt_valid_o, 0);
    check("postrst_draining", draining_o, 0);
    check("postrst_done", done_o, 0);
    check("postrst_cycle", cycle_o, 0);
    push_exp(K_IREG, 8'd1, 64'h55, 64'h1);
    mmio(1'b1, A_IREG, 64'h55, 64'h1);
    push_exp(K_FREG, 8'd0, 64'h66, 64'h2);
    mmio(1'b1, A_FREG, 64'h66, 64'h2);
    push_exp(K_STREAM, 8'd0, 64'h77, 64'h3);
    mmio(1'b1, A_STREAM, 64'h77, 64'h3);
    idle(4);
    check("postrst_queue_empty", exp_q.size(), 0);

    // SIMLEN=100 with no stop: done from cycle 100.
    simlen_i = 32'd100;
    do_reset();
    push_exp(K_SIMLEN, 8'd0, 64'h0, 64'h0);
    while (tb_cyc < 104) begin
      if (tb_cyc == 99)  check("simlen_done@99", done_o, 0);
      if (tb_cyc == 100) check("simlen_done@100", done_o, 1);
      if (tb_cyc == 100) check("simlen_draining@100", draining_o, 0);
      step();
    end
    check("simlen_queue_empty", exp_q.size(), 0);

    // SIMLEN with same-cycle IREG hit: hit first, then SIMLEN; DONE ignores hits.
    simlen_i = 32'd30;
    do_reset();
    while (tb_cyc < 29) step();
    push_exp(K_IREG, 8'd1, 64'h99, 64'h9);
    push_exp(K_SIMLEN, 8'd0, 64'h0, 64'h0);
    mmio(1'b1, A_IREG, 64'h99, 64'h9);
    check("simlen_hit_done@30", done_o, 1);
    mmio(1'b1, A_FREG, 64'hAB, 64'h0);
    idle(4);
    check("simlen_hit_queue_empty", exp_q.size(), 0);

    // SIMLEN overrides a same-cycle STOP: no drain, straight to DONE.
    simlen_i = 32'd40;
    do_reset();
    while (tb_cyc < 39) step();
    push_exp(K_STOP, 8'd0, 64'h0, 64'h0);
    push_exp(K_SIMLEN, 8'd0, 64'h0, 64'h0);
    mmio(1'b1, A_STOP, 64'h1, 64'h1);
    check("simlen_stop_done@40", done_o, 1);
    check("simlen_stop_draining@40", draining_o, 0);
    idle(4);
    check("simlen_stop_queue_empty", exp_q.size(), 0);

    // simlen_i=0: never done without stop.
    simlen_i = 32'd0;
    do_reset();
    idle(120);
    check("nosimlen_done", done_o, 0);
    check("nosimlen_cycle", cycle_o, tb_cyc);

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_event_monitor.md
Name: mmio_event_monitor

Overview:
- Synthesizable MMIO signature decoder placed directly downstream of the tiny SoC's MMIO master port, in place of ad-hoc bench decoding.
- Classifies testbench-signature writes (stop, trap, integer/float register dump, register stream), numbers them, and queues them with taint data in an event FIFO for the logging stage.
- Owns end-of-run sequencing: stop drain countdown, trap policy and SIMLEN cutoff, signalled by done_o.

Parameters:
- ADDR_W, 32, MMIO address width
- DATA_W, 64, MMIO write-data width
- FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)
- STOP_DRAIN, 50, extra cycles run after a stop/trap before done
- ADDR_STOP, 32'h6000_0000, stop signature address
- ADDR_TRAP, 32'h6000_0008, trap signature address
- ADDR_IREG, 32'h6000_0010, integer register dump address
- ADDR_FREG, 32'h6000_0018, float register dump address
- ADDR_STREAM, 32'h6000_0020, register stream address

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mmio_req_i  in  1  MMIO request
- mmio_we_i  in  1  MMIO write enable
- mmio_addr_i  in  ADDR_W  MMIO address
- mmio_wdata_i  in  DATA_W  MMIO write data
- mmio_wdata_t0_i  in  DATA_W  taint of write data
- simlen_i  in  32  run length in cycles; 0 = unlimited
- dontstop_on_trap_i  in  1  1 = trap does not start drain
- evt_valid_o  out  1  FIFO head valid
- evt_ready_i  in  1  consumer accepts head
- evt_kind_o  out  3  0 STOP, 1 TRAP, 2 IREG, 3 FREG, 4 STREAM, 5 SIMLEN
- evt_idx_o  out  8  per-kind sequence index
- evt_data_o  out  DATA_W  captured wdata (0 for STOP/TRAP/SIMLEN)
- evt_taint_o  out  DATA_W  captured wdata taint (0 for STOP/TRAP/SIMLEN)
- draining_o  out  1  state == DRAIN
- done_o  out  1  state == DONE (sticky until reset)
- overflow_o  out  1  sticky: event dropped due to full FIFO
- cycle_o  out  32  cycles since reset release

Behaviour:
- Reset (rst_i sampled high): state RUN, FIFO empty, cycle_o=0, ireg_idx=1, freg_idx=0, stream_idx=0; all outputs 0. Reset mid-run or mid-drain discards queued events.
- cycle_o increments every non-reset cycle, saturating at 2^32-1.
- Hit decode (single cycle, registered into FIFO next edge): STOP/IREG/FREG/STREAM need mmio_req_i & mmio_we_i & exact address; TRAP needs mmio_req_i & address only (read or write). Addresses are disjoint, so at most one hit per cycle.
- Hits are captured only in RUN; ignored in DRAIN and DONE.
- IREG/FREG/STREAM: enqueue {kind, current idx, wdata, wdata_t0}; idx increments by 1 (8-bit wrap 255->0) whether or not the push succeeded.
- STOP: enqueue STOP (idx 0); RUN->DRAIN, drain counter = STOP_DRAIN.
- TRAP: enqueue TRAP (idx 0); if dontstop_on_trap_i=0, RUN->DRAIN as for STOP; otherwise stay RUN.
- DRAIN: counter decrements each cycle; DRAIN->DONE when counter is 0. done_o first high exactly STOP_DRAIN+1 cycles after the capture edge of the stop/trap.
- SIMLEN: if simlen_i!=0 and cycle_o == simlen_i-1 in RUN or DRAIN: in RUN, enqueue SIMLEN (idx 0) after any same-cycle hit event (hit first, SIMLEN next cycle via 1-entry pending slot); next state DONE. SIMLEN overrides STOP/TRAP same cycle.
- FIFO: first-word-fall-through; evt_valid_o = !empty; pop on evt_valid_o & evt_ready_i. Push while full succeeds only if a pop occurs in the same cycle; otherwise the event is dropped and overflow_o sets. Push into empty FIFO is visible on evt_valid_o the cycle after the hit.
- DONE: no new events; FIFO keeps draining to the consumer; done_o stays 1.

Test Plan:
- Reset, then IREG writes wdata 0x11,0x22,t0 0x0,0xFF -> events (IREG,1,0x11,0x0),(IREG,2,0x22,0xFF) in order, evt_ready_i held 1.
- STOP write at cycle 20, STOP_DRAIN=50 -> STOP event; draining_o cycles 21..70; done_o first high at cycle 71; IREG write at cycle 30 produces no event.
- TRAP read with dontstop_on_trap_i=1 -> TRAP event, state stays RUN; repeat with 0 -> drain starts, done after STOP_DRAIN+1 cycles.
- evt_ready_i=0, 10 STREAM writes, FIFO_DEPTH=8 -> 8 events idx 0..7 retained, overflow_o=1, next STREAM write gets idx 10.
- simlen_i=100, no stop -> SIMLEN event, done_o high at cycle 100; simlen_i=0 -> never done without stop.
- Full FIFO with simultaneous pop and FREG push -> push accepted, overflow_o stays 0; rst_i mid-drain -> RUN, FIFO empty, indices reset.
